// File: rtl/seg7_pkg.sv
// ============================================================
// seg7_pkg : shared types and segment codes for seg7_display_ctrl
// Revision 1.0
// ============================================================
`default_nettype none

package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    localparam int NUM_DIGITS = 8;
    localparam int NUM_BCD    = 5;
    localparam int BIN_W      = 16;
    localparam int BCD_W      = 4 * NUM_BCD;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================
// bin2bcd_seq : sequential 16-bit double-dabble binary to 5-digit BCD
// Revision 1.0
// ============================================================
`default_nettype none

module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic                clk_in,
    input  logic                reset_n,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin,
    output logic [BCD_W-1:0]    bcd,
    output logic                busy,
    output logic                done
);

    localparam int SR_W = BCD_W + BIN_W;

    conv_state_t         state;
    conv_state_t         state_next;
    logic [SR_W-1:0]     shift_q;
    logic [4:0]          count_q;
    logic                last_shift_done;

    // One double-dabble iteration: correct every BCD nibble >= 5, then shift
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] v);
        logic [SR_W-1:0] t;
        t = v;
        for (int k = 0; k < NUM_BCD; k++) begin
            if (t[BIN_W + 4*k +: 4] >= 4'd5) begin
                t[BIN_W + 4*k +: 4] = t[BIN_W + 4*k +: 4] + 4'd3;
            end
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

    assign last_shift_done = (count_q == 5'(BIN_W));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_shift_done) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // SHIFT lasts 17 cycles: 16 shifting cycles and one settle cycle before COMMIT
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state   <= IDLE;
            shift_q <= '0;
            count_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_q <= {{BCD_W{1'b0}}, bin};
                        count_q <= '0;
                    end
                end
                SHIFT: begin
                    if (!last_shift_done) begin
                        shift_q <= dabble_step(shift_q);
                        count_q <= count_q + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bcd  = shift_q[SR_W-1:BIN_W];
    assign busy = (state != IDLE);
    assign done = (state == COMMIT);

endmodule

`default_nettype wire

// File: rtl/seg7_display_ctrl.sv
// ============================================================
// seg7_display_ctrl : captures a 16-bit value, converts it to BCD and
//                     scans it onto an 8-digit multiplexed 7-segment display
// Revision 1.0
// ============================================================
`default_nettype none

module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV   = 100000,
    parameter int BLANK_LEADING = 1
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic [15:0] value_in,
    output logic [7:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        busy
);

    localparam int PRESC_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int DIGIT_W = $clog2(NUM_DIGITS);

    logic [BIN_W-1:0]   cap_q;
    logic [BCD_W-1:0]   disp_q;
    logic [PRESC_W-1:0] presc_q;
    logic [DIGIT_W-1:0] digit_q;

    logic               start;
    logic               conv_busy;
    logic               conv_done;
    logic [BCD_W-1:0]   conv_bcd;
    logic               wrap;
    logic [3:0]         nibble;
    logic               is_bcd_digit;
    logic               lead_zero;
    logic [6:0]         seg_next;

    // A new value is only taken when the converter is idle, so the last stable input always wins
    assign start = !conv_busy && (value_in != cap_q);

    bin2bcd_seq u_bin2bcd (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .start   (start),
        .bin     (value_in),
        .bcd     (conv_bcd),
        .busy    (conv_busy),
        .done    (conv_done)
    );

    assign busy = conv_busy;
    assign wrap = (presc_q == PRESC_W'(REFRESH_DIV - 1));

    always_comb begin
        nibble       = 4'd0;
        is_bcd_digit = 1'b1;
        lead_zero    = 1'b0;
        case (digit_q)
            3'd0: nibble = disp_q[3:0];
            3'd1: begin
                nibble    = disp_q[7:4];
                lead_zero = (disp_q[19:4] == 16'd0);
            end
            3'd2: begin
                nibble    = disp_q[11:8];
                lead_zero = (disp_q[19:8] == 12'd0);
            end
            3'd3: begin
                nibble    = disp_q[15:12];
                lead_zero = (disp_q[19:12] == 8'd0);
            end
            3'd4: begin
                nibble    = disp_q[19:16];
                lead_zero = (disp_q[19:16] == 4'd0);
            end
            default: is_bcd_digit = 1'b0;
        endcase

        seg_next = SEG_BLANK;
        if (is_bcd_digit && !((BLANK_LEADING != 0) && lead_zero)) begin
            seg_next = seg_decode(nibble);
        end
    end

    // The digit being driven is the one indexed before the advance, so digit 0 comes first
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            cap_q   <= '0;
            disp_q  <= '0;
            presc_q <= '0;
            digit_q <= '0;
            an_n    <= 8'hFF;
            seg_n   <= SEG_BLANK;
            dp_n    <= 1'b1;
        end else begin
            dp_n <= 1'b1;
            if (start) begin
                cap_q <= value_in;
            end
            if (conv_done) begin
                disp_q <= conv_bcd;
            end
            if (wrap) begin
                presc_q <= '0;
                digit_q <= digit_q + DIGIT_W'(1);
                an_n    <= ~(8'h01 << digit_q);
                seg_n   <= seg_next;
            end else begin
                presc_q <= presc_q + PRESC_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg7_display_ctrl.sv
// ============================================================
// tb_seg7_display_ctrl : scoreboard bench with an arithmetic reference model
// Revision 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seg7_display_ctrl;

    localparam int DIV = 4;

    logic        clk_in   = 1'b0;
    logic        reset_n  = 1'b0;
    logic [15:0] value_in = 16'd0;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        busy;

    seg7_display_ctrl #(.REFRESH_DIV(DIV), .BLANK_LEADING(1)) dut (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .value_in (value_in),
        .an_n     (an_n),
        .seg_n    (seg_n),
        .dp_n     (dp_n),
        .busy     (busy)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [15:0] value;
        int          due;
        int          gen;
    } conv_exp_t;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        int         edge_no;
    } scan_exp_t;

    conv_exp_t conv_q[$];
    scan_exp_t scan_q[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state, advanced on every rising edge
    int          cyc           = 0;
    int          rst_gen       = 0;
    int          last_rst_edge = 0;
    bit          m_in_reset    = 1'b1;
    logic [15:0] m_cap         = 16'd0;
    logic [15:0] m_shown       = 16'd0;
    logic [15:0] m_pend_val    = 16'd0;
    bit          m_pend        = 1'b0;
    int          m_pend_due    = 0;
    bit          m_busy        = 1'b0;
    logic [7:0]  m_last_an     = 8'hFF;
    logic [6:0]  m_last_seg    = 7'h7F;
    int          m_k;
    conv_exp_t   m_cx;
    scan_exp_t   m_sx;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int k);
        int p;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (k >= 5) return 7'h7F;
        if (k > 0 && v < p) return 7'h7F;
        return seg_tab[(v / p) % 10];
    endfunction

    always @(posedge clk_in) begin
        cyc = cyc + 1;
        if (!reset_n) begin
            m_in_reset    = 1'b1;
            rst_gen       = rst_gen + 1;
            last_rst_edge = cyc;
            m_cap         = 16'd0;
            m_shown       = 16'd0;
            m_pend        = 1'b0;
            m_busy        = 1'b0;
            if (m_last_an != 8'hFF || m_last_seg != 7'h7F) begin
                m_sx.an = 8'hFF; m_sx.seg = 7'h7F; m_sx.edge_no = cyc;
                scan_q.push_back(m_sx);
                m_last_an = 8'hFF; m_last_seg = 7'h7F;
            end
        end else begin
            m_in_reset = 1'b0;
            if ((cyc - last_rst_edge) % DIV == 0) begin
                m_k = ((cyc - last_rst_edge) / DIV - 1) % 8;
                m_sx.an      = ~(8'h01 << m_k);
                m_sx.seg     = exp_seg(int'(m_shown), m_k);
                m_sx.edge_no = cyc;
                scan_q.push_back(m_sx);
                m_last_an  = m_sx.an;
                m_last_seg = m_sx.seg;
            end
            if (!m_pend && value_in != m_cap) begin
                m_cap      = value_in;
                m_pend     = 1'b1;
                m_pend_val = value_in;
                m_pend_due = cyc + 18;
                m_cx.value = value_in; m_cx.due = cyc + 18; m_cx.gen = rst_gen;
                conv_q.push_back(m_cx);
            end else if (m_pend && cyc == m_pend_due) begin
                m_shown = m_pend_val;
                m_pend  = 1'b0;
            end
            m_busy = m_pend;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors = vectors + 1;
        if (act != exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int          seen_gen  = 0;
    logic [19:0] prev_disp = 20'd0;
    logic [7:0]  prev_an   = 8'hFF;
    logic [6:0]  prev_seg  = 7'h7F;
    conv_exp_t   mon_cx;
    scan_exp_t   mon_sx;

    always @(negedge clk_in) begin
        if (cyc > 0) begin
            chk("busy", int'(busy), int'(m_busy));
            chk("dp_n", int'(dp_n), 1);
            if (m_in_reset) begin
                chk("reset_an_n", int'(an_n), 8'hFF);
                chk("reset_seg_n", int'(seg_n), 7'h7F);
            end

            if (seen_gen != rst_gen) begin
                seen_gen = rst_gen;
                while (conv_q.size() > 0 && conv_q[0].gen != rst_gen) void'(conv_q.pop_front());
                chk("reset_disp", int'(dut.disp_q), 0);
                prev_disp = dut.disp_q;
            end else if (dut.disp_q != prev_disp) begin
                if (conv_q.size() == 0) begin
                    chk("unexpected_disp", int'(dut.disp_q), int'(prev_disp));
                end else begin
                    mon_cx = conv_q.pop_front();
                    chk("disp_value", int'(dut.disp_q), int'(to_bcd(int'(mon_cx.value))));
                    chk("disp_cycle", cyc, mon_cx.due);
                end
                prev_disp = dut.disp_q;
            end
            while (conv_q.size() > 0 && conv_q[0].due < cyc) begin
                mon_cx = conv_q.pop_front();
                chk("disp_timeout", int'(prev_disp), int'(to_bcd(int'(mon_cx.value))));
            end

            if (an_n != prev_an || seg_n != prev_seg) begin
                if (scan_q.size() == 0) begin
                    chk("unexpected_scan", int'({an_n, seg_n}), int'({prev_an, prev_seg}));
                end else begin
                    mon_sx = scan_q.pop_front();
                    chk("scan_an_n", int'(an_n), int'(mon_sx.an));
                    chk("scan_seg_n", int'(seg_n), int'(mon_sx.seg));
                    chk("scan_cycle", cyc, mon_sx.edge_no);
                end
                prev_an  = an_n;
                prev_seg = seg_n;
            end
            while (scan_q.size() > 0 && scan_q[0].edge_no < cyc) begin
                mon_sx = scan_q.pop_front();
                chk("scan_timeout", int'({prev_an, prev_seg}), int'({mon_sx.an, mon_sx.seg}));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #2;
    endtask

    int sel;

    initial begin
        reset_n  = 1'b0;
        value_in = 16'd0;
        step(3);
        reset_n = 1'b1;
        step(20);

        value_in = 16'd1234;
        step(50);

        value_in = 16'hFFFF;
        step(50);

        value_in = 16'd55;
        step(5);
        value_in = 16'd89;
        step(70);

        value_in = 16'd4181;
        step(9);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        step(60);

        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       value_in = 16'($urandom_range(0, 9));
                1:       value_in = 16'($urandom_range(10, 999));
                default: value_in = 16'($urandom);
            endcase
            step($urandom_range(1, 40));
            if ($urandom_range(0, 9) == 0) begin
                reset_n = 1'b0;
                step($urandom_range(1, 3));
                reset_n = 1'b1;
            end
        end
        step(80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg7_display_ctrl.md
SEG7_DISPLAY_CTRL -- requirements
Module: seg7_display_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000: clk_in cycles per digit slot, minimum 2.
REQ-002 SHALL have parameter BLANK_LEADING, default 1: when 1, leading zeros are blanked.
REQ-003 SHALL have port clk_in, input, 1: the single clock. All logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port value_in, input, 16: unsigned value to display. It is the core's Test_variable (Reg_4[15:0]).
REQ-006 SHALL have port an_n, output, 8: digit enables, active-low, one-hot; bit 0 is the rightmost digit.
REQ-007 SHALL have port seg_n, output, 7: segments, active-low, bit order {g,f,e,d,c,b,a}.
REQ-008 SHALL have port dp_n, output, 1: decimal point, active-low.
REQ-009 SHALL have port busy, output, 1: high while a conversion is in progress.

Function
REQ-010 SHALL hold a captured register cap_q[15:0]; in IDLE, when value_in != cap_q, it SHALL load value_in into cap_q and the shift register, then enter SHIFT.
REQ-011 SHALL convert by sequential double-dabble over 16 SHIFT cycles, one bit per cycle, MSB first. Each cycle adds 3 to every BCD nibble >= 5, then shifts left one bit.
REQ-012 SHALL, in the cycle after the 16th shift, enter COMMIT and copy the 5 BCD nibbles into the display register disp_q in one cycle; then go to IDLE.
REQ-013 SHALL update disp_q exactly 18 cycles after the edge at which the change is sampled.
REQ-014 SHALL ignore value_in changes during SHIFT or COMMIT; the next comparison is made in IDLE, so the final stable value is always shown.
REQ-015 SHALL drive busy high in SHIFT and COMMIT, and low in IDLE.
REQ-016 SHALL run a prescaler from 0 to REFRESH_DIV-1 that wraps to 0. At wrap, the digit index 0..7 SHALL advance and wrap 7->0.
REQ-017 SHALL register an_n, seg_n and dp_n so that they change only on the clock edge where the digit index advances.
REQ-018 SHALL show disp_q nibble k on digits 0..4 via the standard 0-9 decoder. Digits 5..7 SHALL always be blank (seg_n=7'h7F), with their an_n bit still asserted in its slot.
REQ-019 SHALL, when BLANK_LEADING=1, blank any digit 1..4 whose nibble and all higher nibbles are zero. Digit 0 is never blanked.
REQ-020 SHALL drive dp_n=1 at all times.
REQ-021 SHALL show codes 0..9 only; a nibble >9 is unreachable and, if it occurs, SHALL display blank.
REQ-022 SHALL, at the maximum input 16'hFFFF, display 65535 with no overflow.

Reset
REQ-023 SHALL, while reset_n=0 at a clock edge, set: state=IDLE, cap_q=0, shift register=0, disp_q=0, prescaler=0, digit index=0, an_n=8'hFF, seg_n=7'h7F, dp_n=1, busy=0.
REQ-024 SHALL abandon any conversion in progress when reset occurs mid-operation; disp_q SHALL read 0 with no partial result.
REQ-025 SHALL keep an_n=8'hFF after reset release until the first prescaler wrap. The first digit driven is digit 0.
REQ-026 SHALL, if value_in != 0 at reset release, start a conversion on the first clock edge after release.

Structure
REQ-027 SHALL place the following in the shared package seg7_pkg: state enum {IDLE, SHIFT, COMMIT}, NUM_DIGITS=8, NUM_BCD=5, the 7-bit segment constants for 0-9, and SEG_BLANK=7'h7F.
REQ-028 SHALL implement the converter as sub-module bin2bcd_seq (start, bin[15:0], bcd[19:0], busy, done). The scanner and decoder SHALL stay in the top.
REQ-029 SHALL be usable directly as the consumer of the core's Test_variable in the FPGA top level, sharing clk_in.

Verification
REQ-030 SHALL verify: reset_n=0 for 3 cycles -> an_n=8'hFF, seg_n=7'h7F, busy=0. After release with value_in=0, the first wrap gives an_n=8'hFE, seg_n=7'h40.
REQ-031 SHALL verify: value_in 0->16'd1234 -> busy rises next cycle; disp_q=20'h01234 after exactly 18 cycles. With REFRESH_DIV=4, digits 0..3 show 4,3,2,1 and digits 4..7 are blank.
REQ-032 SHALL verify: value_in=16'hFFFF -> digits 0..4 show 5,3,5,5,6 and digits 5..7 are blank.
REQ-033 SHALL verify: value_in 55->89 on cycle 5 of a conversion -> 55 is committed first, a second conversion starts and completes, and 89 is finally displayed.
REQ-034 SHALL verify: reset_n pulsed low on cycle 9 of the conversion of 16'd4181 -> disp_q=0 and busy=0; after release, 4181 is displayed 19 cycles later.
REQ-035 SHALL verify: REFRESH_DIV=4 run for 40 cycles -> an_n cycles through FE, FD, FB, F7, EF, DF, BF, 7F, with each value held exactly 4 cycles.
